// File: rtl/iter_mac.sv
`default_nettype none
// ============================================================================
// Module      : iter_mac
// Description : Iterative multiply / multiply-accumulate unit (MULT, MADD,
//               MSUB). Retires BPC multiplier bits per cycle using a
//               sign-magnitude scheme, then applies the sign and the
//               accumulate step in a single finishing cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module iter_mac #(
  parameter int WIDTH = 32,
  parameter int BPC   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     opa_i,
  input  logic [WIDTH-1:0]     opb_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic                 annul_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   result_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_num_steps = WIDTH / BPC;
  localparam int c_cnt_w     = $clog2(c_num_steps + 1);

  localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(c_num_steps - 1);
  localparam logic [c_cnt_w-1:0]   c_cnt_one  = c_cnt_w'(1);
  localparam logic [WIDTH-1:0]     c_one_w    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0]   c_one_2w   = (2*WIDTH)'(1);

  localparam logic [1:0] c_op_mult = 2'b00;
  localparam logic [1:0] c_op_madd = 2'b01;
  localparam logic [1:0] c_op_msub = 2'b10;
  localparam logic [1:0] c_op_rsvd = 2'b11;

  // Reject a step size that does not split the multiplier evenly.
  generate
    if ((BPC < 1) || (BPC > WIDTH) || ((WIDTH % BPC) != 0)) begin : g_bpc_check
      $error("iter_mac: BPC must be in 1..WIDTH and divide WIDTH");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  // The multiplicand is kept pre-shifted to the current bit position so each
  // CALC step only needs a small shift-and-add, not a variable barrel shift.
  logic [2*WIDTH-1:0] r_mag_a_sh;
  logic [WIDTH-1:0]   r_mag_b;
  logic               r_neg;
  logic [1:0]         r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_p;
  logic [c_cnt_w-1:0] r_cnt;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic               w_accept;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_pp;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_result;
  logic               w_last_step;

  assign w_accept    = start_i & ~annul_i & (op_i != c_op_rsvd);
  assign w_neg_a     = signed_i & opa_i[WIDTH-1];
  assign w_neg_b     = signed_i & opb_i[WIDTH-1];
  // For the most negative value the two's-complement negation wraps back to
  // 2^(WIDTH-1), which is exactly the unsigned magnitude we want.
  assign w_abs_a     = w_neg_a ? (~opa_i + c_one_w) : opa_i;
  assign w_abs_b     = w_neg_b ? (~opb_i + c_one_w) : opb_i;
  assign w_last_step = (r_cnt == c_cnt_last);
  assign busy_o      = (r_state != S_IDLE);

  // Partial product for the BPC low multiplier bits at the current position.
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < BPC; i++) begin
      if (r_mag_b[i]) begin
        w_pp = w_pp + (r_mag_a_sh << i);
      end
    end
  end

  // Apply the sign to the magnitude product, then the accumulate step.
  always_comb begin
    w_prod   = r_neg ? (~r_p + c_one_2w) : r_p;
    w_result = w_prod;
    case (r_op)
      c_op_mult: w_result = w_prod;
      c_op_madd: w_result = r_acc + w_prod;
      c_op_msub: w_result = r_acc - w_prod;
      default:   w_result = w_prod;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a flush always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (w_last_step) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (annul_i) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Operand capture on accept, then one shift-and-add step per CALC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag_a_sh <= '0;
      r_mag_b    <= '0;
      r_neg      <= 1'b0;
      r_op       <= c_op_mult;
      r_acc      <= '0;
      r_p        <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mag_a_sh <= {{WIDTH{1'b0}}, w_abs_a};
            r_mag_b    <= w_abs_b;
            r_neg      <= signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
            r_op       <= op_i;
            r_acc      <= acc_i;
            r_p        <= '0;
            r_cnt      <= '0;
          end
        end
        S_CALC: begin
          r_p        <= r_p + w_pp;
          r_mag_a_sh <= r_mag_a_sh << BPC;
          r_mag_b    <= r_mag_b >> BPC;
          r_cnt      <= r_cnt + c_cnt_one;
        end
        default: begin
          r_p <= r_p;
        end
      endcase
    end
  end

  // Publish the result and pulse done on leaving FIN, unless flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      done_o <= (r_state == S_FIN) & ~annul_i;
      if ((r_state == S_FIN) && !annul_i) begin
        result_o <= w_result;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iter_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_mac
// Description : Self-checking bench for iter_mac. One main instance
//               (32/2) plus three parameter variants (32/1, 32/4, 16/4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_mac;

  logic        clk;
  logic        rst;
  logic [3:0]  start;
  logic [1:0]  op;
  logic        sg;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [63:0] acc;
  logic        annul;

  logic [3:0]  busy_w;
  logic [3:0]  done_w;
  logic [63:0] res_w [4];
  logic [31:0] res16;

  int tests_run;
  int tests_failed;
  logic [63:0] sb_q [$];

  int n_of     [4] = '{16, 32, 8, 4};
  int width_of [4] = '{32, 32, 32, 16};

  assign res_w[3] = {32'h0, res16};

  iter_mac #(.WIDTH(32), .BPC(2)) u_main (
    .clk(clk), .rst(rst), .start_i(start[0]), .op_i(op), .signed_i(sg),
    .opa_i(opa), .opb_i(opb), .acc_i(acc), .annul_i(annul),
    .busy_o(busy_w[0]), .done_o(done_w[0]), .result_o(res_w[0])
  );

  iter_mac #(.WIDTH(32), .BPC(1)) u_b1 (
    .clk(clk), .rst(rst), .start_i(start[1]), .op_i(op), .signed_i(sg),
    .opa_i(opa), .opb_i(opb), .acc_i(acc), .annul_i(annul),
    .busy_o(busy_w[1]), .done_o(done_w[1]), .result_o(res_w[1])
  );

  iter_mac #(.WIDTH(32), .BPC(4)) u_b4 (
    .clk(clk), .rst(rst), .start_i(start[2]), .op_i(op), .signed_i(sg),
    .opa_i(opa), .opb_i(opb), .acc_i(acc), .annul_i(annul),
    .busy_o(busy_w[2]), .done_o(done_w[2]), .result_o(res_w[2])
  );

  iter_mac #(.WIDTH(16), .BPC(4)) u_w16 (
    .clk(clk), .rst(rst), .start_i(start[3]), .op_i(op), .signed_i(sg),
    .opa_i(opa[15:0]), .opb_i(opb[15:0]), .acc_i(acc[31:0]), .annul_i(annul),
    .busy_o(busy_w[3]), .done_o(done_w[3]), .result_o(res16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden model: plain full-width arithmetic, reduced modulo 2^(2*w).
  function automatic logic [63:0] model(input int w, input logic [1:0] o, input logic s,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] ac);
    logic signed [127:0] sa, sb, p, r;
    logic [31:0] am, bm;
    logic [63:0] mask;
    am   = (w == 16) ? {16'h0, a[15:0]} : a;
    bm   = (w == 16) ? {16'h0, b[15:0]} : b;
    mask = (w == 16) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    sa = $signed({96'h0, am});
    sb = $signed({96'h0, bm});
    if (s && am[w-1]) sa = sa - (128'sd1 <<< w);
    if (s && bm[w-1]) sb = sb - (128'sd1 <<< w);
    p = sa * sb;
    case (o)
      2'b00:   r = p;
      2'b01:   r = $signed({64'h0, ac & mask}) + p;
      default: r = $signed({64'h0, ac & mask}) - p;
    endcase
    return r[63:0] & mask;
  endfunction

  // Drive one start (caller is mid-cycle) and follow it to done; no checking.
  task automatic exec_op(input int d, input logic [1:0] o, input logic s,
                         input logic [31:0] a, input logic [31:0] b, input logic [63:0] ac,
                         output int done_cyc, output logic [63:0] res, output int busy_bad);
    int limit;
    logic exp_busy;
    limit    = n_of[d] + 20;
    done_cyc = -1;
    res      = '0;
    busy_bad = 0;
    op = o; sg = s; opa = a; opb = b; acc = ac;
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    opa = $urandom; opb = $urandom; acc = {$urandom, $urandom};
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      exp_busy = (k <= n_of[d] + 1);
      if (busy_w[d] !== exp_busy) busy_bad++;
      if (done_w[d] === 1'b1) begin
        done_cyc = k;
        res      = res_w[d];
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy_w[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy_w[0]); end
    tests_run++;
    if (done_w[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done_w[0]); end
    tests_run++;
    if (res_w[0] !== 64'h0) begin tests_failed++; $display("FAIL reset_result: got %h want 0", res_w[0]); end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (busy_w !== 4'b0 || done_w !== 4'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL idle_quiet: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_unsigned_mult();
    int dc, bb;
    logic [63:0] r, e;
    sb_q.push_back(64'hFFFFFFFE_00000001);
    exec_op(0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, dc, r, bb);
    e = sb_q.pop_front();
    tests_run++;
    if (dc !== 18) begin tests_failed++; $display("FAIL umult_latency: got %0d want 18", dc); end
    tests_run++;
    if (bb !== 0) begin tests_failed++; $display("FAIL umult_busy: got %0d bad cycles want 0", bb); end
    tests_run++;
    if (r !== e) begin tests_failed++; $display("FAIL umult_result: got %h want %h", r, e); end
    @(negedge clk);
    tests_run++;
    if (done_w[0] !== 1'b0) begin tests_failed++; $display("FAIL umult_done_width: got %b want 0", done_w[0]); end
  endtask

  // Signed edge cases and MADD accumulate/wrap, as a compact table.
  task automatic test_signed_madd();
    logic [1:0]  t_op  [4] = '{2'b00, 2'b10, 2'b01, 2'b01};
    logic        t_sg  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] t_a   [4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFE, 32'h1};
    logic [31:0] t_b   [4] = '{32'h5, 32'h80000000, 32'h4, 32'h1};
    logic [63:0] t_acc [4] = '{64'h0, 64'h0, 64'h10, 64'hFFFFFFFF_FFFFFFFF};
    logic [63:0] t_exp [4] = '{64'hFFFFFFFF_FFFFFFF1, 64'hC0000000_00000000,
                               64'h00000000_00000008, 64'h0};
    int dc, bb;
    logic [63:0] r, e;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(t_exp[i]);
      exec_op(0, t_op[i], t_sg[i], t_a[i], t_b[i], t_acc[i], dc, r, bb);
      e = sb_q.pop_front();
      tests_run++;
      if (dc !== 18) begin tests_failed++; $display("FAIL edge%0d_latency: got %0d want 18", i, dc); end
      tests_run++;
      if (r !== e) begin tests_failed++; $display("FAIL edge%0d_result: got %h want %h", i, r, e); end
    end
  endtask

  task automatic test_annul();
    int dc, bb, bad;
    logic [63:0] r, rr;
    rr = model(32, 2'b00, 1'b1, 32'h00001234, 32'hFFFFFFB3, 64'h0);
    sb_q.push_back(rr);
    exec_op(0, 2'b00, 1'b1, 32'h00001234, 32'hFFFFFFB3, 64'h0, dc, r, bb);
    rr = sb_q.pop_front();
    tests_run++;
    if (r !== rr) begin tests_failed++; $display("FAIL annul_setup: got %h want %h", r, rr); end
    // Flush mid-CALC in cycle 5.
    @(negedge clk);
    op = 2'b00; sg = 1'b0; opa = 32'd7; opb = 32'd9; acc = 64'h0; start[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0;
    bad = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (busy_w[0] !== 1'b1) bad++;
    end
    annul = 1'b1;
    @(posedge clk); #1; annul = 1'b0;
    for (int k = 6; k <= 30; k++) begin
      @(negedge clk);
      if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL annul_calc_ctrl: got %0d bad cycles want 0", bad); end
    tests_run++;
    if (res_w[0] !== rr) begin tests_failed++; $display("FAIL annul_calc_hold: got %h want %h", res_w[0], rr); end
    // Flush in the FIN cycle (17).
    op = 2'b01; sg = 1'b0; opa = 32'd3; opb = 32'd3; acc = 64'h5; start[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0;
    for (int k = 1; k <= 17; k++) @(negedge clk);
    annul = 1'b1;
    @(posedge clk); #1; annul = 1'b0;
    bad = 0;
    for (int k = 18; k <= 40; k++) begin
      @(negedge clk);
      if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL annul_fin_ctrl: got %0d bad cycles want 0", bad); end
    tests_run++;
    if (res_w[0] !== rr) begin tests_failed++; $display("FAIL annul_fin_hold: got %h want %h", res_w[0], rr); end
    // Start together with annul in IDLE, then a reserved-op start.
    bad = 0;
    op = 2'b00; start[0] = 1'b1; annul = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0; annul = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy_w[0] !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL annul_with_start: got %0d busy cycles want 0", bad); end
    bad = 0;
    op = 2'b11; start[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL reserved_op: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_ignored_start();
    int dc, bad;
    logic [63:0] e, r;
    e = model(32, 2'b00, 1'b1, 32'hFFFF0001, 32'h00000321, 64'h0);
    sb_q.push_back(e);
    op = 2'b00; sg = 1'b1; opa = 32'hFFFF0001; opb = 32'h00000321; acc = 64'h0; start[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0;
    dc = -1; r = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 3) begin
        op = 2'b01; sg = 1'b0; opa = 32'd5; opb = 32'd5; acc = 64'd1; start[0] = 1'b1;
        @(posedge clk); #1; start[0] = 1'b0;
      end else if (done_w[0] === 1'b1) begin
        dc = k; r = res_w[0];
        break;
      end
    end
    e = sb_q.pop_front();
    tests_run++;
    if (dc !== 18) begin tests_failed++; $display("FAIL busy_start_latency: got %0d want 18", dc); end
    tests_run++;
    if (r !== e) begin tests_failed++; $display("FAIL busy_start_result: got %h want %h", r, e); end
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL busy_start_queued: got %0d active cycles want 0", bad); end
  endtask

  // Random ops issued back-to-back (each start lands in the prior done cycle).
  task automatic test_back_to_back_sweep();
    int dc, bb;
    logic [63:0] r, e, ac;
    logic [31:0] a, b;
    logic [1:0]  o;
    logic        s;
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
        o  = 2'($urandom_range(0, 2));
        s  = 1'($urandom_range(0, 1));
        a  = $urandom;
        b  = $urandom;
        ac = {$urandom, $urandom};
        if (i == 1) a = (width_of[d] == 16) ? 32'h00008000 : 32'h80000000;
        if (i == 2) begin a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; end
        sb_q.push_back(model(width_of[d], o, s, a, b, ac));
        exec_op(d, o, s, a, b, ac, dc, r, bb);
        e = sb_q.pop_front();
        tests_run++;
        if (dc !== n_of[d] + 2) begin
          tests_failed++;
          $display("FAIL sweep%0d_%0d_latency: got %0d want %0d", d, i, dc, n_of[d] + 2);
        end
        tests_run++;
        if (bb !== 0) begin tests_failed++; $display("FAIL sweep%0d_%0d_busy: got %0d bad cycles want 0", d, i, bb); end
        tests_run++;
        if (r !== e) begin tests_failed++; $display("FAIL sweep%0d_%0d_result: got %h want %h", d, i, r, e); end
      end
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b1; start = 4'b0; op = 2'b00; sg = 1'b0;
    opa = '0; opb = '0; acc = '0; annul = 1'b0;
    test_reset();
    test_unsigned_mult();
    test_signed_madd();
    test_annul();
    test_ignored_start();
    test_back_to_back_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
